ex_fwd_ctrl: RTL and testbench

- Execute-stage operand controller for the three-stage RISC-V pipeline.
- Tracks the instruction currently in writeback (rd, write enable, load flag) and drives the 2-bit selects of the operand-A and operand-B three-input muxes: register file, WB ALU result, or WB load data.
- Sequences variable-latency load returns: holds the pipeline until load data is valid, with a timeout.
- Also issues the register-file write enable for the WB instruction.

---
 rtl/ex_fwd_ctrl.sv | 82 ++++++++
 tb/tb_ex_fwd_ctrl.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/ex_fwd_ctrl.sv
// Execute-stage operand controller: tracks the writeback slot, drives operand
// forwarding selects, and holds the pipeline while a load's data is outstanding.
module ex_fwd_ctrl #(
  parameter int REG_AW  = 5,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic [REG_AW-1:0] ex_rs1,
  input  logic [REG_AW-1:0] ex_rs2,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_we,
  input  logic              ex_load,
  input  logic              flush,
  input  logic              mem_rvalid,
  output logic [1:0]        sel_a,
  output logic [1:0]        sel_b,
  output logic              stall,
  output logic [REG_AW-1:0] wb_rd,
  output logic              rf_we,
  output logic              mem_err
);

  localparam logic [0:0] S_RUN  = 1'b0;
  localparam logic [0:0] S_WAIT = 1'b1;

  localparam logic [1:0] SEL_RF  = 2'd0;
  localparam logic [1:0] SEL_ALU = 2'd1;
  localparam logic [1:0] SEL_LD  = 2'd2;

  logic [0:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             wb_we;
  logic             wb_load;
  logic             waiting;
  logic             timeout;
  logic             nxt_we;
  logic             nxt_load;

  assign waiting  = (state == S_WAIT) & ~mem_rvalid;
  assign timeout  = waiting & (cnt == CNT_W'(TIMEOUT - 1));
  assign stall    = waiting & ~timeout;
  assign mem_err  = timeout;

  assign nxt_we   = ex_valid & ex_we & ~flush;
  assign nxt_load = ex_valid & ex_load & ~flush;

  // Load results only reach the register file on the cycle their data returns.
  assign rf_we = wb_we & (~wb_load | ((state == S_WAIT) & mem_rvalid));

  function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] rs);
    if (ex_valid && wb_we && (wb_rd == rs) && (rs != '0))
      return wb_load ? SEL_LD : SEL_ALU;
    return SEL_RF;
  endfunction

  assign sel_a = fwd_sel(ex_rs1);
  assign sel_b = fwd_sel(ex_rs2);

  // Any advance (including a timeout abort) re-evaluates the wait state from
  // the instruction entering WB, so a load following an abort is still tracked.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_RUN;
      cnt     <= '0;
      wb_rd   <= '0;
      wb_we   <= 1'b0;
      wb_load <= 1'b0;
    end else if (!stall) begin
      wb_rd   <= ex_rd;
      wb_we   <= nxt_we;
      wb_load <= nxt_load;
      state   <= nxt_load ? S_WAIT : S_RUN;
      cnt     <= '0;
    end else begin
      cnt     <= cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_ex_fwd_ctrl.sv
// Directed bench for ex_fwd_ctrl: forwarding, x0 guard, load wait, flush,
// load timeout and asynchronous reset during a pending load.
module tb_ex_fwd_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       ex_valid, ex_we, ex_load, flush, mem_rvalid;
  logic [4:0] ex_rs1, ex_rs2, ex_rd;
  logic [1:0] sel_a, sel_b;
  logic       stall, rf_we, mem_err;
  logic [4:0] wb_rd;

  int checks   = 0;
  int failures = 0;
  int nstall;
  int nerr;

  always #5 clk = ~clk;

  ex_fwd_ctrl #(.REG_AW(5), .TIMEOUT(64), .CNT_W(7)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .ex_rd(ex_rd), .ex_we(ex_we), .ex_load(ex_load), .flush(flush),
    .mem_rvalid(mem_rvalid), .sel_a(sel_a), .sel_b(sel_b), .stall(stall),
    .wb_rd(wb_rd), .rf_we(rf_we), .mem_err(mem_err)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ex(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic we, input logic ld);
    ex_valid = v; ex_rs1 = rs1; ex_rs2 = rs2; ex_rd = rd; ex_we = we; ex_load = ld;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; mem_rvalid = 1'b0;
    set_ex(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    #3;
    chk("rst_sel_a", sel_a, 2'd0);
    chk("rst_sel_b", sel_b, 2'd0);
    chk("rst_stall", stall, 1'b0);
    chk("rst_rf_we", rf_we, 1'b0);
    chk("rst_mem_err", mem_err, 1'b0);
    chk("rst_wb_rd", wb_rd, 5'd0);
    step(); step();
    rst = 1'b0;

    // ALU forward: addi x5 then add x6,x5,x5
    set_ex(1'b1, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0);
    step();
    set_ex(1'b1, 5'd5, 5'd5, 5'd6, 1'b1, 1'b0);
    #1;
    chk("alu_sel_a", sel_a, 2'd1);
    chk("alu_sel_b", sel_b, 2'd1);
    chk("alu_stall", stall, 1'b0);
    chk("alu_rf_we", rf_we, 1'b1);
    chk("alu_wb_rd", wb_rd, 5'd5);

    // x0 guard: WB writes x0, EX reads x0
    set_ex(1'b1, 5'd3, 5'd3, 5'd0, 1'b1, 1'b0);
    step();
    set_ex(1'b1, 5'd0, 5'd0, 5'd8, 1'b1, 1'b0);
    #1;
    chk("x0_sel_a", sel_a, 2'd0);
    chk("x0_sel_b", sel_b, 2'd0);

    // invalid EX never forwards
    step();
    set_ex(1'b0, 5'd8, 5'd0, 5'd2, 1'b0, 1'b0);
    #1;
    chk("inv_sel_a", sel_a, 2'd0);
    ex_valid = 1'b1;
    #1;
    chk("val_sel_a", sel_a, 2'd1);

    // load-use with 3 cycles of missing data
    set_ex(1'b1, 5'd0, 5'd0, 5'd7, 1'b1, 1'b1);
    step();
    set_ex(1'b1, 5'd0, 5'd7, 5'd10, 1'b1, 1'b0);
    nstall = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (stall) nstall++;
      chk("ld_wait_rf_we", rf_we, 1'b0);
      chk("ld_wait_wb_rd", wb_rd, 5'd7);
      step();
    end
    chk("ld_stall_cnt", nstall, 3);
    mem_rvalid = 1'b1;
    #1;
    chk("ld_ret_stall", stall, 1'b0);
    chk("ld_ret_rf_we", rf_we, 1'b1);
    chk("ld_ret_sel_b", sel_b, 2'd2);
    step();
    mem_rvalid = 1'b0;
    #1;
    chk("ld_run_stall", stall, 1'b0);
    chk("ld_run_wb_rd", wb_rd, 5'd10);

    // flush turns add x9 into a bubble
    set_ex(1'b1, 5'd0, 5'd0, 5'd9, 1'b1, 1'b0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    set_ex(1'b1, 5'd9, 5'd0, 5'd11, 1'b1, 1'b0);
    #1;
    chk("fl_sel_a", sel_a, 2'd0);
    chk("fl_rf_we", rf_we, 1'b0);

    // timeout: load with data never returning
    set_ex(1'b1, 5'd0, 5'd0, 5'd12, 1'b1, 1'b1);
    step();
    set_ex(1'b1, 5'd0, 5'd0, 5'd13, 1'b1, 1'b0);
    nstall = 0;
    nerr = 0;
    for (int k = 1; k < 64; k++) begin
      #1;
      if (stall) nstall++;
      if (mem_err) nerr++;
      step();
    end
    chk("to_stall_cnt", nstall, 63);
    chk("to_early_err", nerr, 0);
    #1;
    chk("to_mem_err", mem_err, 1'b1);
    chk("to_stall", stall, 1'b0);
    chk("to_rf_we", rf_we, 1'b0);
    step();
    #1;
    chk("to_err_pulse", mem_err, 1'b0);
    chk("to_run_stall", stall, 1'b0);
    chk("to_wb_rd", wb_rd, 5'd13);

    // async reset during a pending load
    set_ex(1'b1, 5'd0, 5'd0, 5'd14, 1'b1, 1'b1);
    step();
    set_ex(1'b1, 5'd14, 5'd14, 5'd15, 1'b1, 1'b0);
    #1;
    chk("ar_pre_stall", stall, 1'b1);
    chk("ar_pre_sel_a", sel_a, 2'd2);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_stall", stall, 1'b0);
    chk("ar_sel_a", sel_a, 2'd0);
    chk("ar_sel_b", sel_b, 2'd0);
    chk("ar_rf_we", rf_we, 1'b0);
    #1;
    rst = 1'b0;
    mem_rvalid = 1'b1;
    #1;
    chk("ar_post_sel_a", sel_a, 2'd0);
    chk("ar_post_rf_we", rf_we, 1'b0);
    chk("ar_post_wb_rd", wb_rd, 5'd0);
    mem_rvalid = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
